// File: rtl/obstacle_scheduler_if.sv
// Obstacle scheduler bus: frame/control pulses and random word in,
// per-slot obstacle state and status out.
interface obstacle_scheduler_if;
    logic       tick;
    logic       start;
    logic       freeze;
    logic       clear;
    logic [3:0] speed;
    logic [4:0] rand_data;
    logic [2:0] obs_valid;
    logic [9:0] obs_x0;
    logic [9:0] obs_x1;
    logic [9:0] obs_x2;
    logic [1:0] obs_type0;
    logic [1:0] obs_type1;
    logic [1:0] obs_type2;
    logic       spawn;
    logic [1:0] state;

    modport master (
        output tick, start, freeze, clear, speed, rand_data,
        input  obs_valid, obs_x0, obs_x1, obs_x2,
        input  obs_type0, obs_type1, obs_type2, spawn, state
    );

    modport slave (
        input  tick, start, freeze, clear, speed, rand_data,
        output obs_valid, obs_x0, obs_x1, obs_x2,
        output obs_type0, obs_type1, obs_type2, spawn, state
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler for the dinosaur game: decides when obstacles spawn,
// picks their type from the random word and scrolls up to three slots left
// once per frame tick. All outputs come straight from registers.
module obstacle_scheduler #(
    parameter logic [9:0] SPAWN_X        = 10'd640,
    parameter logic [7:0] MIN_GAP        = 8'd20,
    parameter int         GAP_SHIFT      = 2,
    parameter logic [3:0] BIRD_MIN_SPEED = 4'd6
) (
    input  logic                  clk,
    input  logic                  RESET,
    obstacle_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     state_r;
    logic [2:0] valid_r;
    logic [9:0] x_r    [3];
    logic [1:0] type_r [3];
    logic [7:0] gap_r;
    logic       spawn_r;

    logic [2:0] nxt_valid_s;
    logic [9:0] nxt_x_s    [3];
    logic [1:0] nxt_type_s [3];
    logic [7:0] nxt_gap_s;
    logic       nxt_spawn_s;
    logic       free_found_s;
    logic [1:0] free_idx_s;
    logic [1:0] spawn_type_s;
    logic [7:0] gap_reload_s;
    logic [9:0] speed_ext_s;

    // Slot update for one RUN tick: scroll/retire, then count the gap or spawn.
    always_comb begin
        speed_ext_s = {6'd0, bus.speed};

        // Only slots free before this tick may receive a spawn, so the
        // search looks at the registered flags rather than post-move ones.
        free_found_s = 1'b1;
        free_idx_s   = 2'd0;
        if (!valid_r[0]) begin
            free_idx_s = 2'd0;
        end else if (!valid_r[1]) begin
            free_idx_s = 2'd1;
        end else if (!valid_r[2]) begin
            free_idx_s = 2'd2;
        end else begin
            free_found_s = 1'b0;
        end

        // Birds are only fair once the game is fast enough to jump them.
        if ((bus.rand_data[1:0] == 2'd3) && (bus.speed < BIRD_MIN_SPEED)) begin
            spawn_type_s = 2'd0;
        end else begin
            spawn_type_s = bus.rand_data[1:0];
        end
        gap_reload_s = MIN_GAP + (8'(bus.rand_data) << GAP_SHIFT);

        nxt_valid_s = valid_r;
        for (int i = 0; i < 3; i++) begin
            nxt_x_s[i]    = x_r[i];
            nxt_type_s[i] = type_r[i];
            if (valid_r[i] && (x_r[i] >= speed_ext_s)) begin
                nxt_x_s[i] = x_r[i] - speed_ext_s;
            end else if (valid_r[i]) begin
                // Retiring keeps its last x and type for the render stage.
                nxt_valid_s[i] = 1'b0;
            end else begin
                nxt_valid_s[i] = 1'b0;
            end
        end

        nxt_gap_s   = gap_r;
        nxt_spawn_s = 1'b0;
        if (gap_r != 8'd0) begin
            nxt_gap_s = gap_r - 8'd1;
        end else if (free_found_s) begin
            nxt_valid_s[free_idx_s] = 1'b1;
            nxt_x_s[free_idx_s]     = SPAWN_X;
            nxt_type_s[free_idx_s]  = spawn_type_s;
            nxt_gap_s               = gap_reload_s;
            nxt_spawn_s             = 1'b1;
        end else begin
            // All slots busy: leave the gap at zero so the next tick retries.
            nxt_gap_s = 8'd0;
        end
    end

    // Scheduler FSM and slot registers; priority reset > clear > freeze > start > tick.
    always_ff @(posedge clk) begin
        if (RESET || bus.clear) begin
            state_r <= ST_IDLE;
            valid_r <= 3'b000;
            gap_r   <= 8'd0;
            spawn_r <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                x_r[i]    <= 10'd0;
                type_r[i] <= 2'd0;
            end
        end else if (bus.freeze && (state_r == ST_RUN)) begin
            state_r <= ST_HOLD;
            spawn_r <= 1'b0;
        end else if (bus.start && (state_r == ST_IDLE)) begin
            state_r <= ST_RUN;
            gap_r   <= MIN_GAP;
            spawn_r <= 1'b0;
        end else if (bus.tick && (state_r == ST_RUN)) begin
            valid_r <= nxt_valid_s;
            gap_r   <= nxt_gap_s;
            spawn_r <= nxt_spawn_s;
            for (int i = 0; i < 3; i++) begin
                x_r[i]    <= nxt_x_s[i];
                type_r[i] <= nxt_type_s[i];
            end
        end else begin
            spawn_r <= 1'b0;
        end
    end

    assign bus.obs_valid = valid_r;
    assign bus.obs_x0    = x_r[0];
    assign bus.obs_x1    = x_r[1];
    assign bus.obs_x2    = x_r[2];
    assign bus.obs_type0 = type_r[0];
    assign bus.obs_type1 = type_r[1];
    assign bus.obs_type2 = type_r[2];
    assign bus.spawn     = spawn_r;
    assign bus.state     = state_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Testbench for obstacle_scheduler: directed scenarios plus a randomized run
// checked against a behavioural model of the obstacle game rules.
module tb_obstacle_scheduler;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    obstacle_scheduler_if bus();

    obstacle_scheduler dut (.clk(clk), .RESET(RESET), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_speed = 0;
    int cur_rand  = 0;

    // Behavioural model state
    int m_state;
    bit m_valid [3];
    int m_x     [3];
    int m_type  [3];
    int m_gap;
    bit m_spawn;

    function automatic logic [2:0] mv();
        return {m_valid[2], m_valid[1], m_valid[0]};
    endfunction

    task automatic model_step(input bit r, input bit t, input bit st, input bit fr,
                              input bit cl, input int sp, input int rd);
        bit was [3];
        int tgt;
        m_spawn = 1'b0;
        if (r || cl) begin
            m_state = 0; m_gap = 0;
            for (int i = 0; i < 3; i++) begin m_valid[i] = 1'b0; m_x[i] = 0; m_type[i] = 0; end
        end else if (fr && m_state == 1) begin
            m_state = 2;
        end else if (st && m_state == 0) begin
            m_state = 1; m_gap = 20;
        end else if (t && m_state == 1) begin
            for (int i = 0; i < 3; i++) was[i] = m_valid[i];
            for (int i = 0; i < 3; i++)
                if (m_valid[i]) begin
                    if (m_x[i] >= sp) m_x[i] = m_x[i] - sp;
                    else m_valid[i] = 1'b0;
                end
            if (m_gap > 0) m_gap = m_gap - 1;
            else begin
                tgt = -1;
                for (int i = 2; i >= 0; i--) if (!was[i]) tgt = i;
                if (tgt >= 0) begin
                    m_valid[tgt] = 1'b1;
                    m_x[tgt]     = 640;
                    m_type[tgt]  = ((rd % 4) == 3 && sp < 6) ? 0 : (rd % 4);
                    m_gap        = (20 + rd * 4) % 256;
                    m_spawn      = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit t, input bit st, input bit fr,
                         input bit cl, input int sp, input int rd);
        RESET         = r;
        bus.tick      = t;
        bus.start     = st;
        bus.freeze    = fr;
        bus.clear     = cl;
        bus.speed     = 4'(sp);
        bus.rand_data = 5'(rd);
        model_step(r, t, st, fr, cl, sp, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();       cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_speed, cur_rand); endtask
    task automatic do_tick();    idle(); cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cur_speed, cur_rand); endtask
    task automatic do_start();   cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cur_speed, cur_rand); endtask
    task automatic do_clear();   cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur_speed, cur_rand); endtask
    task automatic do_freeze();  cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cur_speed, cur_rand); endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 5);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 5);
        n_tests++;
        if (bus.state !== 2'd0 || bus.obs_valid !== 3'b000 || bus.spawn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got state=%0d valid=%b spawn=%b, expected 0 000 0", bus.state, bus.obs_valid, bus.spawn);
        end
        n_tests++;
        if (bus.obs_x0 !== 10'd0 || bus.obs_x1 !== 10'd0 || bus.obs_x2 !== 10'd0 ||
            bus.obs_type0 !== 2'd0 || bus.obs_type1 !== 2'd0 || bus.obs_type2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_slots: got x=%0d,%0d,%0d type=%0d,%0d,%0d, expected all 0",
                     bus.obs_x0, bus.obs_x1, bus.obs_x2, bus.obs_type0, bus.obs_type1, bus.obs_type2);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 5);
    endtask

    task automatic test_first_spawn();
        int nspawn;
        cur_speed = 4; cur_rand = 5'h05;
        do_start();
        n_tests++;
        if (bus.state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", bus.state); end
        nspawn = 0;
        for (int i = 0; i < 20; i++) begin do_tick(); if (bus.spawn !== 1'b0 || bus.obs_valid !== 3'b000) nspawn++; end
        n_tests++;
        if (nspawn != 0) begin n_fail++; $display("FAIL first_gap: got %0d early spawns expected 0", nspawn); end
        do_tick();
        n_tests++;
        if (bus.spawn !== 1'b1 || bus.obs_valid !== 3'b001 || bus.obs_x0 !== 10'd640 || bus.obs_type0 !== 2'd1) begin
            n_fail++;
            $display("FAIL first_spawn: got spawn=%b valid=%b x0=%0d type0=%0d expected 1 001 640 1",
                     bus.spawn, bus.obs_valid, bus.obs_x0, bus.obs_type0);
        end
        idle();
        n_tests++;
        if (bus.spawn !== 1'b0) begin n_fail++; $display("FAIL spawn_pulse_width: got %b expected 0", bus.spawn); end
        cur_rand = 5'h00;
        nspawn = 0;
        for (int i = 0; i < 40; i++) begin do_tick(); if (bus.spawn !== 1'b0) nspawn++; end
        n_tests++;
        if (nspawn != 0) begin n_fail++; $display("FAIL reload_gap_40: got %0d early spawns expected 0", nspawn); end
        do_tick();
        n_tests++;
        if (bus.spawn !== 1'b1 || bus.obs_valid !== 3'b011 || bus.obs_x1 !== 10'd640 || bus.obs_x0 !== 10'(640 - 4 * 41)) begin
            n_fail++;
            $display("FAIL second_spawn: got spawn=%b valid=%b x0=%0d x1=%0d expected 1 011 %0d 640",
                     bus.spawn, bus.obs_valid, bus.obs_x0, bus.obs_x1, 640 - 4 * 41);
        end
        do_clear();
    endtask

    task automatic test_move_retire();
        cur_speed = 15; cur_rand = 5'h1f;
        do_start();
        for (int i = 0; i < 21; i++) do_tick();
        n_tests++;
        if (bus.obs_type0 !== 2'd3) begin n_fail++; $display("FAIL bird_fast: got type0=%0d expected 3", bus.obs_type0); end
        for (int i = 0; i < 42; i++) do_tick();
        n_tests++;
        if (bus.obs_x0 !== 10'd10) begin n_fail++; $display("FAIL move_to_10: got x0=%0d expected 10", bus.obs_x0); end
        cur_speed = 4;
        do_tick();
        n_tests++;
        if (bus.obs_x0 !== 10'd6) begin n_fail++; $display("FAIL move_to_6: got x0=%0d expected 6", bus.obs_x0); end
        do_tick();
        n_tests++;
        if (bus.obs_x0 !== 10'd2) begin n_fail++; $display("FAIL move_to_2: got x0=%0d expected 2", bus.obs_x0); end
        do_tick();
        n_tests++;
        if (bus.obs_valid[0] !== 1'b0 || bus.obs_x0 !== 10'd2) begin
            n_fail++; $display("FAIL retire: got valid0=%b x0=%0d expected 0 2", bus.obs_valid[0], bus.obs_x0);
        end
        do_clear();
    endtask

    task automatic test_bird_gating();
        cur_speed = 5; cur_rand = 5'h03;
        do_start();
        for (int i = 0; i < 21; i++) do_tick();
        n_tests++;
        if (bus.spawn !== 1'b1 || bus.obs_type0 !== 2'd0) begin
            n_fail++; $display("FAIL bird_slow: got spawn=%b type0=%0d expected 1 0", bus.spawn, bus.obs_type0);
        end
        cur_speed = 6;
        for (int i = 0; i < 33; i++) do_tick();
        n_tests++;
        if (bus.spawn !== 1'b1 || bus.obs_valid[1] !== 1'b1 || bus.obs_type1 !== 2'd3) begin
            n_fail++; $display("FAIL bird_min_speed: got spawn=%b valid1=%b type1=%0d expected 1 1 3",
                               bus.spawn, bus.obs_valid[1], bus.obs_type1);
        end
        do_clear();
    endtask

    task automatic test_slots_full();
        int k;
        cur_speed = 15; cur_rand = 0;
        do_start();
        k = 0; while (!m_valid[0] && k < 40) begin do_tick(); k++; end
        cur_rand = 5'h1f;
        k = 0; while (!m_valid[1] && k < 40) begin do_tick(); k++; end
        k = 0; while (m_valid[0] && k < 80) begin do_tick(); k++; end
        n_tests++;
        if (bus.obs_valid !== 3'b010) begin n_fail++; $display("FAIL full_setup_a: got valid=%b expected 010", bus.obs_valid); end
        cur_speed = 0; cur_rand = 0;
        k = 0; while (!m_valid[0] && k < 200) begin do_tick(); k++; end
        k = 0; while (!m_valid[2] && k < 40) begin do_tick(); k++; end
        n_tests++;
        if (bus.obs_valid !== 3'b111) begin n_fail++; $display("FAIL full_setup_b: got valid=%b expected 111", bus.obs_valid); end
        k = 0; while (m_gap != 0 && k < 40) begin do_tick(); k++; end
        do_tick();
        n_tests++;
        if (bus.spawn !== 1'b0 || bus.obs_valid !== 3'b111) begin
            n_fail++; $display("FAIL full_withheld: got spawn=%b valid=%b expected 0 111", bus.spawn, bus.obs_valid);
        end
        cur_speed = 15;
        k = 0;
        while (m_valid[1] && k < 40) begin
            do_tick(); k++;
            n_tests++;
            if (bus.spawn !== 1'b0) begin n_fail++; $display("FAIL full_retry_spawn: got spawn=%b expected 0", bus.spawn); end
        end
        n_tests++;
        if (bus.obs_valid !== 3'b101) begin n_fail++; $display("FAIL slot1_retire: got valid=%b expected 101", bus.obs_valid); end
        do_tick();
        n_tests++;
        if (bus.spawn !== 1'b1 || bus.obs_valid !== 3'b111 || bus.obs_x1 !== 10'd640) begin
            n_fail++; $display("FAIL refill_slot1: got spawn=%b valid=%b x1=%0d expected 1 111 640",
                               bus.spawn, bus.obs_valid, bus.obs_x1);
        end
        do_clear();
    endtask

    task automatic test_freeze_clear();
        cur_speed = 10; cur_rand = 5'h1f;
        do_start();
        for (int i = 0; i < 21 + 34; i++) do_tick();
        n_tests++;
        if (bus.obs_x0 !== 10'd300) begin n_fail++; $display("FAIL pre_freeze_x0: got %0d expected 300", bus.obs_x0); end
        do_freeze();
        for (int i = 0; i < 10; i++) do_tick();
        n_tests++;
        if (bus.obs_x0 !== 10'd300 || bus.state !== 2'd2) begin
            n_fail++; $display("FAIL hold: got x0=%0d state=%0d expected 300 2", bus.obs_x0, bus.state);
        end
        do_start();
        n_tests++;
        if (bus.state !== 2'd2) begin n_fail++; $display("FAIL start_in_hold: got state=%0d expected 2", bus.state); end
        do_clear();
        n_tests++;
        if (bus.obs_valid !== 3'b000 || bus.state !== 2'd0) begin
            n_fail++; $display("FAIL clear: got valid=%b state=%0d expected 000 0", bus.obs_valid, bus.state);
        end
    endtask

    task automatic test_simultaneous();
        cur_speed = 10; cur_rand = 5'h1f;
        do_start();
        for (int i = 0; i < 21; i++) do_tick();
        idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, cur_speed, cur_rand);
        n_tests++;
        if (bus.obs_x0 !== 10'd640 || bus.state !== 2'd2) begin
            n_fail++; $display("FAIL tick_freeze: got x0=%0d state=%0d expected 640 2", bus.obs_x0, bus.state);
        end
        do_clear();
        cur_speed = 4; cur_rand = 0;
        do_start();
        for (int i = 0; i < 20; i++) do_tick();
        idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cur_speed, cur_rand);
        n_tests++;
        if (bus.state !== 2'd0 || bus.obs_valid !== 3'b000 || bus.spawn !== 1'b0) begin
            n_fail++; $display("FAIL tick_clear: got state=%0d valid=%b spawn=%b expected 0 000 0",
                               bus.state, bus.obs_valid, bus.spawn);
        end
    endtask

    task automatic test_random();
        bit r, t, st, fr, cl;
        int sp, rd;
        sp = 12;
        for (int c = 0; c < 4000; c++) begin
            r  = ($urandom_range(0, 499) == 0);
            t  = ($urandom_range(0, 4) < 2);
            st = ($urandom_range(0, 29) == 0);
            fr = ($urandom_range(0, 149) == 0);
            cl = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 63) == 0) sp = $urandom_range(0, 15);
            rd = $urandom_range(0, 31);
            cycle(r, t, st, fr, cl, sp, rd);
            n_tests++;
            if (bus.state !== 2'(m_state) || bus.obs_valid !== mv() || bus.spawn !== m_spawn ||
                bus.obs_x0 !== 10'(m_x[0]) || bus.obs_x1 !== 10'(m_x[1]) || bus.obs_x2 !== 10'(m_x[2]) ||
                bus.obs_type0 !== 2'(m_type[0]) || bus.obs_type1 !== 2'(m_type[1]) || bus.obs_type2 !== 2'(m_type[2])) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got st=%0d v=%b sp=%b x=%0d,%0d,%0d t=%0d,%0d,%0d expected st=%0d v=%b sp=%b x=%0d,%0d,%0d t=%0d,%0d,%0d",
                         c, bus.state, bus.obs_valid, bus.spawn, bus.obs_x0, bus.obs_x1, bus.obs_x2,
                         bus.obs_type0, bus.obs_type1, bus.obs_type2, m_state, mv(), m_spawn,
                         m_x[0], m_x[1], m_x[2], m_type[0], m_type[1], m_type[2]);
            end
        end
    endtask

    initial begin
        bus.tick = 1'b0; bus.start = 1'b0; bus.freeze = 1'b0; bus.clear = 1'b0;
        bus.speed = 4'd0; bus.rand_data = 5'd0;
        test_reset();
        test_first_spawn();
        test_move_retire();
        test_bird_gating();
        test_slots_full();
        test_freeze_clear();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
